// File: rtl/muxn_rr_reg_pkg.sv
// Shared types and the round-robin search used by the arbiter and by checking models.
package muxn_pkg;

    typedef enum logic {MODE_SEL, MODE_RR} mux_mode_e;

    localparam int MAX_CH = 32;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } rr_gnt_t;

    // Scan from ptr+1 upward, wrapping at num_ch, and return the first valid channel.
    function automatic rr_gnt_t rr_next(input int num_ch, input int ptr,
                                        input logic [MAX_CH-1:0] valid);
        rr_gnt_t r;
        int      c;
        r = '0;
        for (int i = 1; i <= MAX_CH; i++) begin
            c = ptr + i;
            if (c >= num_ch) c = c - num_ch;
            if (i <= num_ch && !r.found && c >= 0 && c < MAX_CH && valid[c]) begin
                r.found = 1'b1;
                r.idx   = 8'(c);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_rr_reg_if.sv
// Handshake bundle between N producers, the registered mux and its single consumer.
interface muxn_intf
    import muxn_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    mux_mode_e          mode;
    logic [SEL_W-1:0]   sel;
    logic [NUM_CH-1:0]  in_valid;
    logic [WIDTH-1:0]   in_data [NUM_CH];
    logic [NUM_CH-1:0]  in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_ready;

    modport dut (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport tb (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/muxn_rr_reg_arbiter.sv
// Combinational round-robin picker: first requester after ptr, wrapping at NUM_CH.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);
    // Only the low SEL_W index bits can be non-zero for this channel count.
    rr_gnt_t nxt_unused;

    assign nxt_unused = rr_next(NUM_CH, int'(ptr), MAX_CH'(req));
    assign gnt_valid  = nxt_unused.found;
    assign gnt_idx    = nxt_unused.idx[SEL_W-1:0];
endmodule

// File: rtl/muxn_rr_reg.sv
// N-to-1 registered mux with explicit-select or round-robin grant and output backpressure.
module muxn_rr_reg
    import muxn_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input logic   clk,
    input logic   rst_n,
    muxn_intf.dut bus
);
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic              load_en;
    logic [NUM_CH-1:0] in_ready;

    logic              vld_p0;
    logic [WIDTH-1:0]  data_p0;
    logic [SEL_W-1:0]  ch_p0;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_found)
    );

    assign load_en = !vld_p0 || bus.out_ready;

    // An out-of-range select is filtered before it can index in_valid.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (bus.mode == MODE_RR) begin
            gnt_idx   = rr_idx;
            gnt_valid = rr_found;
        end else if (int'(bus.sel) < NUM_CH) begin
            gnt_idx   = bus.sel;
            gnt_valid = bus.in_valid[bus.sel];
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && gnt_valid) in_ready[gnt_idx] = 1'b1;
    end

    // Stage p0: output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ch_p0   <= '0;
            rr_ptr  <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            vld_p0 <= gnt_valid;
            if (gnt_valid) begin
                data_p0 <= bus.in_data[gnt_idx];
                ch_p0   <= gnt_idx;
                rr_ptr  <= gnt_idx;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.out_ch    = ch_p0;
endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg: a 4-channel instance plus a 3-channel one for select range.
module tb_muxn_rr_reg;
    import muxn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muxn_intf #(.NUM_CH(4), .WIDTH(4)) bus4 ();
    muxn_intf #(.NUM_CH(3), .WIDTH(4)) bus3 ();

    muxn_rr_reg #(.NUM_CH(4), .WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    muxn_rr_reg #(.NUM_CH(3), .WIDTH(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus4.mode = MODE_SEL; bus4.sel = '0; bus4.in_valid = '0; bus4.out_ready = 1'b0;
        bus3.mode = MODE_SEL; bus3.sel = '0; bus3.in_valid = '0; bus3.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus4.in_data[i] = '0;
        for (int i = 0; i < 3; i++) bus3.in_data[i] = '0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        bus4.mode = MODE_RR;
        bus4.in_valid = 4'b1111;
        #1;
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus4.out_data); end
        n_checks++; if (bus4.out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d want 0", bus4.out_ch); end
        n_checks++; if (bus4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid: got %b want 0", bus4.out_valid); end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_sel_basic;
        bus4.mode = MODE_SEL;
        bus4.sel = 2'd2;
        bus4.in_valid = 4'b0100;
        bus4.in_data[2] = 4'hA;
        bus4.out_ready = 1'b1;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b0100) begin n_fail++; $display("FAIL sel_in_ready: got %b want 0100", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL sel_out_valid: got %b want 1", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 4'hA) begin n_fail++; $display("FAIL sel_out_data: got %h want a", bus4.out_data); end
        n_checks++; if (bus4.out_ch !== 2'd2) begin n_fail++; $display("FAIL sel_out_ch: got %0d want 2", bus4.out_ch); end
        bus4.in_valid = 4'b0000;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL sel_nogrant_ready: got %b want 0000", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL sel_drain_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 4'hA) begin n_fail++; $display("FAIL sel_drain_hold_data: got %h want a", bus4.out_data); end
        n_checks++; if (bus4.out_ch !== 2'd2) begin n_fail++; $display("FAIL sel_drain_hold_ch: got %0d want 2", bus4.out_ch); end
    endtask

    task automatic test_out_of_range;
        bus3.mode = MODE_SEL;
        bus3.sel = 2'd3;
        bus3.in_valid = 3'b111;
        bus3.in_data[0] = 4'h1; bus3.in_data[1] = 4'h6; bus3.in_data[2] = 4'hE;
        bus3.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (bus3.in_ready !== 3'b000) begin n_fail++; $display("FAIL oor_in_ready[%0d]: got %b want 000", k, bus3.in_ready); end
            n_checks++; if (bus3.out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_out_valid[%0d]: got %b want 0", k, bus3.out_valid); end
            step();
        end
        bus3.sel = 2'd1;
        #1;
        n_checks++; if (bus3.in_ready !== 3'b010) begin n_fail++; $display("FAIL oor_inrange_ready: got %b want 010", bus3.in_ready); end
        step();
        n_checks++; if (bus3.out_ch !== 2'd1) begin n_fail++; $display("FAIL oor_inrange_ch: got %0d want 1", bus3.out_ch); end
        n_checks++; if (bus3.out_data !== 4'h6) begin n_fail++; $display("FAIL oor_inrange_data: got %h want 6", bus3.out_data); end
        bus3.in_valid = '0;
    endtask

    task automatic test_rr_fair;
        idle_inputs();
        apply_reset();
        bus4.mode = MODE_RR;
        bus4.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) bus4.in_data[i] = 4'(i);
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (bus4.in_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_fair_ready[%0d]: got %b want %b", k, bus4.in_ready, 4'(1 << (k % 4))); end
            step();
            n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_fair_valid[%0d]: got %b want 1", k, bus4.out_valid); end
            n_checks++; if (bus4.out_ch !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_fair_ch[%0d]: got %0d want %0d", k, bus4.out_ch, k % 4); end
            n_checks++; if (bus4.out_data !== 4'(k % 4)) begin n_fail++; $display("FAIL rr_fair_data[%0d]: got %h want %h", k, bus4.out_data, k % 4); end
        end
    endtask

    task automatic test_rr_skip;
        logic [1:0] exp_ch [3];
        logic [3:0] exp_rdy [3];
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd3; exp_ch[2] = 2'd0;
        exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b1000; exp_rdy[2] = 4'b0001;
        idle_inputs();
        apply_reset();
        bus4.mode = MODE_RR;
        bus4.in_valid = 4'b1001;
        bus4.in_data[0] = 4'h5;
        bus4.in_data[3] = 4'hC;
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus4.in_ready !== exp_rdy[k]) begin n_fail++; $display("FAIL rr_skip_ready[%0d]: got %b want %b", k, bus4.in_ready, exp_rdy[k]); end
            step();
            n_checks++; if (bus4.out_ch !== exp_ch[k]) begin n_fail++; $display("FAIL rr_skip_ch[%0d]: got %0d want %0d", k, bus4.out_ch, exp_ch[k]); end
        end
    endtask

    task automatic test_backpressure;
        bus4.out_ready = 1'b0;
        bus4.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) bus4.in_data[i] = 4'(8 + i);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, bus4.in_ready); end
            n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, bus4.out_valid); end
            n_checks++; if (bus4.out_data !== 4'h5) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 5", k, bus4.out_data); end
            n_checks++; if (bus4.out_ch !== 2'd0) begin n_fail++; $display("FAIL bp_ch[%0d]: got %0d want 0", k, bus4.out_ch); end
            step();
        end
        bus4.out_ready = 1'b1;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0010", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_ch !== 2'd1) begin n_fail++; $display("FAIL bp_release_ch: got %0d want 1", bus4.out_ch); end
        n_checks++; if (bus4.out_data !== 4'h9) begin n_fail++; $display("FAIL bp_release_data: got %h want 9", bus4.out_data); end
        bus4.mode = MODE_SEL;
        bus4.sel = 2'd3;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b1000) begin n_fail++; $display("FAIL mode_sel_ready: got %b want 1000", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_data !== 4'hB) begin n_fail++; $display("FAIL mode_sel_data: got %h want b", bus4.out_data); end
        bus4.mode = MODE_RR;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b0001) begin n_fail++; $display("FAIL mode_rr_ptr_ready: got %b want 0001", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_ch !== 2'd0) begin n_fail++; $display("FAIL mode_rr_ptr_ch: got %0d want 0", bus4.out_ch); end
        n_checks++; if (bus4.out_data !== 4'h8) begin n_fail++; $display("FAIL mode_rr_ptr_data: got %h want 8", bus4.out_data); end
    endtask

    task automatic test_reset_mid;
        bus4.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus4.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", bus4.out_valid); end
        n_checks++; if (bus4.out_data !== 4'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h want 0", bus4.out_data); end
        n_checks++; if (bus4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0000", bus4.in_ready); end
        step();
        rst_n = 1'b1;
        bus4.mode = MODE_RR;
        bus4.in_valid = 4'b1111;
        bus4.out_ready = 1'b1;
        #1;
        n_checks++; if (bus4.in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_after_ready: got %b want 0001", bus4.in_ready); end
        step();
        n_checks++; if (bus4.out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_after_ch: got %0d want 0", bus4.out_ch); end
        n_checks++; if (bus4.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_after_valid: got %b want 1", bus4.out_valid); end
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_out_of_range();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
